// File: rtl/ni_tdm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : ni_tdm_scheduler_if
// Brief   : Core-FIFO read port and NoC-FIFO write port seen by the scheduler.
// Rev     : 1.0  initial release
// ============================================================================
interface ni_tdm_scheduler_if #(
    parameter int MSB_SLOT = 5
);
    localparam int c_DSIZE = 1 << MSB_SLOT;
    localparam int c_RSIZE = 1 << (MSB_SLOT - 1);

    logic               ni_rempty;
    logic [c_RSIZE-1:0] ni_rdata;
    logic [c_RSIZE-1:0] ni_raddr;
    logic               ni_read_en;
    logic               ni_wfull;
    logic [c_DSIZE-1:0] ni_wdata;
    logic               ni_write_en;

    modport master (
        input  ni_rempty, ni_rdata, ni_raddr, ni_wfull,
        output ni_read_en, ni_wdata, ni_write_en
    );

    modport slave (
        output ni_rempty, ni_rdata, ni_raddr, ni_wfull,
        input  ni_read_en, ni_wdata, ni_write_en
    );
endinterface
`default_nettype wire

// File: rtl/ni_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ni_tdm_scheduler
// Brief   : TDM transmit scheduler; packs core packets into flits and injects
//           them only in owned slots. Define NI_SCHED_STATS_EN for stall_cnt.
// Rev     : 1.0  initial release
// ============================================================================
module ni_tdm_scheduler #(
    parameter int MSB_SLOT    = 5,
    parameter int SLOT_BITS   = 3,
    parameter int SLOT_CYCLES = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 sched_en,
    input  wire logic                 cfg_we,
    input  wire logic [SLOT_BITS-1:0] cfg_slot,
    input  wire logic                 cfg_own,
    ni_tdm_scheduler_if.master        ni,
    output logic      [SLOT_BITS-1:0] slot_idx,
    output logic                      busy,
    output logic      [15:0]          flit_cnt
`ifdef NI_SCHED_STATS_EN
    ,
    output logic      [15:0]          stall_cnt
`endif
);
    localparam int c_DSIZE     = 1 << MSB_SLOT;
    localparam int c_NUM_SLOTS = 1 << SLOT_BITS;
    localparam int c_CYC_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POP     = 2'd1,
        S_CAPTURE = 2'd2,
        S_SEND    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CYC_W-1:0]     r_cyc_cnt;
    logic [SLOT_BITS-1:0]   r_slot_idx;
    logic [c_NUM_SLOTS-1:0] r_own;
    logic [15:0]            r_flit_cnt;
    logic [c_DSIZE-1:0]     r_wdata;
    logic                   w_slot_start;
    logic                   w_read_en;
    logic                   w_write_en;

    // Ownership is sampled from the registered table, so a write landing on
    // the current slot's first cycle only matters at that slot's next start.
    assign w_slot_start = sched_en && (r_cyc_cnt == '0) && r_own[r_slot_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc_cnt  <= '0;
            r_slot_idx <= '0;
        end else if (!sched_en) begin
            r_cyc_cnt  <= '0;
            r_slot_idx <= '0;
        end else if (r_cyc_cnt == c_CYC_LAST) begin
            r_cyc_cnt  <= '0;
            r_slot_idx <= r_slot_idx + 1'b1;
        end else begin
            r_cyc_cnt  <= r_cyc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_own <= '0;
        end else if (cfg_we) begin
            r_own[cfg_slot] <= cfg_own;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_read_en   = 1'b0;
        w_write_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_slot_start && !ni.ni_rempty && !ni.ni_wfull) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_read_en   = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_write_en = !ni.ni_wfull;
                if (!ni.ni_wfull) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read data is valid one cycle after the pop, i.e. during CAPTURE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdata <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_wdata <= {ni.ni_raddr, ni.ni_rdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flit_cnt <= '0;
        end else if (w_write_en) begin
            r_flit_cnt <= r_flit_cnt + 16'd1;
        end
    end

`ifdef NI_SCHED_STATS_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_SEND) && ni.ni_wfull)
                  || ((r_state == S_IDLE) && w_slot_start && !ni.ni_rempty && ni.ni_wfull);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Statistics counter is not built in this configuration.
`endif

    assign ni.ni_read_en  = w_read_en;
    assign ni.ni_write_en = w_write_en;
    assign ni.ni_wdata    = r_wdata;
    assign slot_idx       = r_slot_idx;
    assign busy           = (r_state != S_IDLE);
    assign flit_cnt       = r_flit_cnt;

endmodule
`default_nettype wire
